// File: rtl/rv32i_pkg.sv
// Shared timer-peripheral definitions: register offsets, handshake states,
// control register layout and a byte-strobe merge helper.
package rv32i_pkg;

  // Byte offsets of the word registers inside the 32-byte timer window
  localparam logic [4:0] TIMER_CTRL     = 5'h00;
  localparam logic [4:0] TIMER_PRESC    = 5'h04;
  localparam logic [4:0] TIMER_MTIME_LO = 5'h08;
  localparam logic [4:0] TIMER_MTIME_HI = 5'h0C;
  localparam logic [4:0] TIMER_CMP_LO   = 5'h10;
  localparam logic [4:0] TIMER_CMP_HI   = 5'h14;
  localparam logic [4:0] TIMER_STATUS   = 5'h18;

  typedef enum logic {
    TMR_IDLE = 1'b0,
    TMR_RESP = 1'b1
  } timer_state_e;

  // Packed MSB first, so en lands on bit 0 and irq_en on bit 1
  typedef struct packed {
    logic irq_en;
    logic en;
  } timer_ctrl_t;

  // Replace the bytes of old_val selected by strb with the bytes of new_val
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler for the timer: counts enabled clocks and emits a one-cycle tick
// each time the count reaches the programmed divide value, then restarts.
module timer_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic               i_clear,
  input  logic [PRESC_W-1:0] i_presc,
  output logic               o_tick
);

  logic [PRESC_W-1:0] cnt_q;
  logic               hit;

  assign hit = (cnt_q == i_presc);

  // A clear (PRESC rewritten) takes priority and suppresses the tick that cycle
  assign o_tick = i_en & hit & ~i_clear;

  // Count while enabled; hold (not clear) while disabled
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_clear) begin
      cnt_q <= '0;
    end else if (i_en) begin
      cnt_q <= hit ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/lsu_timer_responder.sv
// Memory-mapped 64-bit timer responder on the LSU peripheral handshake.
// Handshake: a request is accepted on any clock edge where i_VALID and o_READY
// are both high; o_READY is high only in IDLE, so the initiator must hold its
// request until then. Exactly one cycle after acceptance o_rvalid pulses for
// one cycle with o_rdata (read value, or 0 for writes).
// Build option TIMER_SNAPSHOT_EN: reading MTIME_LO latches mtime[63:32] into a
// shadow that MTIME_HI reads return, giving tear-free 64-bit reads.
module lsu_timer_responder
  import rv32i_pkg::*;
#(
  parameter int                 ADDR_W    = 5,
  parameter int                 PRESC_W   = 16,
  parameter logic [PRESC_W-1:0] RST_PRESC = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_VALID,
  output logic              o_READY,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_wstrb,
  output logic [31:0]       o_rdata,
  output logic              o_rvalid,
  output logic              o_irq,
  output timer_state_e      o_dbg_state
);

  timer_state_e       state_q, state_d;
  timer_ctrl_t        ctrl_q;
  logic [PRESC_W-1:0] presc_q;
  logic [63:0]        mtime_q, mtime_d;
  logic [63:0]        cmp_q;
  logic               pending_q;
  logic [31:0]        rdata_q, rd_val, mtime_hi_rd;
  logic [ADDR_W-1:0]  word_off;
  logic               accept, wr_hit, rd_acc, tick, presc_clear, w1c;
  logic               sel_ctrl, sel_presc, sel_mlo, sel_mhi, sel_clo, sel_chi, sel_stat;
  logic               unused_addr;

  assign unused_addr = ^i_addr[1:0];
  assign word_off    = {i_addr[ADDR_W-1:2], 2'b00};
  assign accept      = i_VALID & (state_q == TMR_IDLE);
  // Writes with no strobes are acknowledged but change nothing
  assign wr_hit      = accept & i_wr_en & (|i_wstrb);
  assign rd_acc      = accept & ~i_wr_en;
  assign presc_clear = wr_hit & sel_presc;
  assign w1c         = wr_hit & sel_stat & i_wstrb[0] & i_wdata[0];

  // Address decode of the word register being accessed
  always_comb begin
    sel_ctrl  = 1'b0;
    sel_presc = 1'b0;
    sel_mlo   = 1'b0;
    sel_mhi   = 1'b0;
    sel_clo   = 1'b0;
    sel_chi   = 1'b0;
    sel_stat  = 1'b0;
    case (word_off)
      ADDR_W'(TIMER_CTRL):     sel_ctrl  = 1'b1;
      ADDR_W'(TIMER_PRESC):    sel_presc = 1'b1;
      ADDR_W'(TIMER_MTIME_LO): sel_mlo   = 1'b1;
      ADDR_W'(TIMER_MTIME_HI): sel_mhi   = 1'b1;
      ADDR_W'(TIMER_CMP_LO):   sel_clo   = 1'b1;
      ADDR_W'(TIMER_CMP_HI):   sel_chi   = 1'b1;
      ADDR_W'(TIMER_STATUS):   sel_stat  = 1'b1;
      default: ;
    endcase
  end

  // Handshake state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= TMR_IDLE;
    else          state_q <= state_d;
  end

  // Handshake next state and outputs: IDLE accepts, RESP answers for one cycle
  always_comb begin
    state_d  = state_q;
    o_READY  = 1'b0;
    o_rvalid = 1'b0;
    case (state_q)
      TMR_IDLE: begin
        o_READY = 1'b1;
        if (i_VALID) state_d = TMR_RESP;
      end
      TMR_RESP: begin
        o_rvalid = 1'b1;
        state_d  = TMR_IDLE;
      end
      default: state_d = TMR_IDLE;
    endcase
  end

  timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (ctrl_q.en),
    .i_clear (presc_clear),
    .i_presc (presc_q),
    .o_tick  (tick)
  );

  // Control, prescaler and compare registers: byte-strobed software writes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_q  <= '0;
      presc_q <= RST_PRESC;
      cmp_q   <= '0;
    end else if (wr_hit) begin
      if (sel_ctrl && i_wstrb[0]) ctrl_q <= timer_ctrl_t'(i_wdata[1:0]);
      if (sel_presc) presc_q <= PRESC_W'(merge_bytes(32'(presc_q), i_wdata, i_wstrb));
      if (sel_clo) cmp_q[31:0]  <= merge_bytes(cmp_q[31:0], i_wdata, i_wstrb);
      if (sel_chi) cmp_q[63:32] <= merge_bytes(cmp_q[63:32], i_wdata, i_wstrb);
    end
  end

  // mtime next value: a software write to one half overrides the tick and
  // leaves the other half untouched (no carry into it that cycle)
  always_comb begin
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr_hit && sel_mlo) mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], i_wdata, i_wstrb)};
    if (wr_hit && sel_mhi) mtime_d = {merge_bytes(mtime_q[63:32], i_wdata, i_wstrb), mtime_q[31:0]};
  end

  // mtime counter and compare-match pending flag (set beats W1C)
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mtime_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      mtime_q   <= mtime_d;
      pending_q <= (mtime_q >= cmp_q) | (pending_q & ~w1c);
    end
  end

`ifdef TIMER_SNAPSHOT_EN
  logic [31:0] shadow_q;

  // Shadow of the upper half, taken whenever the lower half is read
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)               shadow_q <= '0;
    else if (rd_acc && sel_mlo) shadow_q <= mtime_q[63:32];
  end

  assign mtime_hi_rd = shadow_q;
`else
  assign mtime_hi_rd = mtime_q[63:32];
`endif

  // Read data selection; reserved words and bits read as zero
  always_comb begin
    rd_val = '0;
    if (sel_ctrl)  rd_val = {30'd0, ctrl_q};
    if (sel_presc) rd_val = 32'(presc_q);
    if (sel_mlo)   rd_val = mtime_q[31:0];
    if (sel_mhi)   rd_val = mtime_hi_rd;
    if (sel_clo)   rd_val = cmp_q[31:0];
    if (sel_chi)   rd_val = cmp_q[63:32];
    if (sel_stat)  rd_val = {31'd0, pending_q};
  end

  // Response data register: read value in the RESP cycle, zero otherwise
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rdata_q <= '0;
    else          rdata_q <= rd_acc ? rd_val : 32'd0;
  end

  assign o_rdata     = rdata_q;
  assign o_irq       = pending_q & ctrl_q.irq_en;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_lsu_timer_responder.sv
// Self-checking bench for lsu_timer_responder. mtime is predicted from the
// number of enabled clock edges divided by (PRESC+1), not from a copy of the
// counter logic. Honours TIMER_SNAPSHOT_EN for MTIME_HI expectations.
module tb_lsu_timer_responder;
  import rv32i_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid, ready, wr_en, rvalid, irq;
  logic [4:0]   addr;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  timer_state_e dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc = 0;

  // Reference model state
  logic [63:0] m_base = '0;
  int unsigned m_p = 0, e_on = 0, e_off = 0, acc_edge = 0;
  bit          m_en = 1'b0, m_started = 1'b0;
  logic [31:0] m_shadow = '0;
  logic [31:0] exp_q[$];

  lsu_timer_responder dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_VALID     (valid),
    .o_READY     (ready),
    .i_wr_en     (wr_en),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .i_wstrb     (wstrb),
    .o_rdata     (rdata),
    .o_rvalid    (rvalid),
    .o_irq       (irq),
    .o_dbg_state (dbg_state)
  );

  // Clock and edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mtime value seen by a request accepted at edge ea
  function automatic logic [63:0] mt_at(input int unsigned ea);
    int unsigned last, n;
    if (!m_started) return m_base;
    last = ea - 1;
    if (!m_en && e_off < last) last = e_off;
    n = (last > e_on) ? last - e_on : 0;
    return m_base + 64'(n / (m_p + 1));
  endfunction

  // Driver: one bus transaction, bounded wait for READY
  task automatic access(input bit w, input logic [4:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd);
    int waited = 0;
    rd = '0;
    @(negedge clk);
    valid = 1'b1; wr_en = w; addr = a; wdata = d; wstrb = s;
    while (!ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!ready) begin
      n_cmp++; n_bad++;
      $display("FAIL handshake_timeout observed=ready_low expected=ready_high");
      valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 acc_edge = cyc;
    @(negedge clk);
    check("rvalid_after_accept", rvalid, 1'b1);
    rd = rdata;
    valid = 1'b0; wr_en = 1'b0; wstrb = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    access(1'b1, a, d, s, rd);
    check("write_rdata_zero", rd, 32'd0);
  endtask

  task automatic rd_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    access(1'b0, a, 32'd0, 4'd0, rd);
    check(tag, rd, exp);
  endtask

  task automatic set_mtime(input logic [63:0] v);
    wr(TIMER_MTIME_LO, v[31:0], 4'hF);
    wr(TIMER_MTIME_HI, v[63:32], 4'hF);
    m_base = v; m_started = 1'b0;
  endtask

  task automatic start_timer(input int unsigned p);
    wr(TIMER_PRESC, 32'(p), 4'hF);
    m_p = p;
    wr(TIMER_CTRL, 32'd1, 4'hF);
    e_on = acc_edge; m_en = 1'b1; m_started = 1'b1;
  endtask

  task automatic stop_timer();
    wr(TIMER_CTRL, 32'd0, 4'hF);
    e_off = acc_edge; m_en = 1'b0;
  endtask

  // Read LO then HI and compare both halves against the model
  task automatic read_mtime_check(input string tag);
    logic [31:0] rd;
    logic [63:0] t;
    access(1'b0, TIMER_MTIME_LO, 32'd0, 4'd0, rd);
    t = mt_at(acc_edge);
    m_shadow = t[63:32];
    check({tag, "_lo"}, rd, t[31:0]);
    access(1'b0, TIMER_MTIME_HI, 32'd0, 4'd0, rd);
    t = mt_at(acc_edge);
`ifdef TIMER_SNAPSHOT_EN
    check({tag, "_hi"}, rd, m_shadow);
`else
    check({tag, "_hi"}, rd, t[63:32]);
`endif
  endtask

  initial begin
    logic [31:0] rd0, rd1, v;
    logic [63:0] base;
    logic [3:0]  s;
    logic [4:0]  a;
    int          k, sel;
    logic [4:0]  reg_addr[4];
    logic [31:0] reg_mask[4];
    logic [31:0] reg_val[4];

    // Reset
    valid = 1'b0; wr_en = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", ready, 1'b1);
    check("reset_rvalid", rvalid, 1'b0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_irq", irq, 1'b0);
    check("reset_state", dbg_state, TMR_IDLE);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", ready, 1'b1);

    // First read: mtime 0, response pulse exactly one cycle
    rd_check("reset_mtime_lo", TIMER_MTIME_LO, 32'd0);
    @(negedge clk);
    check("rvalid_one_cycle", rvalid, 1'b0);
    rd_check("reset_presc", TIMER_PRESC, 32'd0);

    // PRESC=3 for 40 clocks, then frozen with CTRL.en=0
    set_mtime(64'd0);
    start_timer(3);
    repeat (40) @(negedge clk);
    read_mtime_check("presc3_run");
    stop_timer();
    read_mtime_check("presc3_stop_a");
    repeat (13) @(negedge clk);
    read_mtime_check("presc3_stop_b");

    // Carry out of the low word with PRESC=0
    set_mtime(64'h0000_0000_FFFF_FFFF);
    start_timer(0);
    read_mtime_check("carry");
    stop_timer();
    read_mtime_check("carry_stop");

    // Randomised runs near the 32-bit wrap
    for (int it = 0; it < 6; it++) begin
      base = {32'($urandom_range(0, 3)), 32'hFFFF_FFFF - 32'($urandom_range(0, 40))};
      set_mtime(base);
      start_timer($urandom_range(0, 4));
      repeat ($urandom_range(2, 60)) @(negedge clk);
      read_mtime_check("rand_run");
      stop_timer();
      repeat ($urandom_range(1, 8)) @(negedge clk);
      read_mtime_check("rand_stop");
    end

    // LO/HI read pair straddling a carry (shadow vs live)
    set_mtime(64'h0000_0001_FFFF_FFFF);
    start_timer(1);
    read_mtime_check("snapshot");
    stop_timer();

    // Compare match and interrupt
    set_mtime(64'd0);
    wr(TIMER_PRESC, 32'd0, 4'hF);
    wr(TIMER_CMP_HI, 32'd0, 4'hF);
    wr(TIMER_CMP_LO, 32'd5, 4'hF);
    wr(TIMER_STATUS, 32'd1, 4'hF);
    rd_check("status_cleared", TIMER_STATUS, 32'd0);
    wr(TIMER_CTRL, 32'd3, 4'hF);
    k = 0;
    while (!irq && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("irq_latency_edges", 64'(k), 64'd6);
    wr(TIMER_CTRL, 32'd2, 4'hF);
    wr(TIMER_STATUS, 32'd1, 4'hF);
    rd_check("status_set_wins", TIMER_STATUS, 32'd1);
    check("irq_held", irq, 1'b1);
    wr(TIMER_CMP_LO, 32'hFFFF_FFFF, 4'hF);
    wr(TIMER_CMP_HI, 32'hFFFF_FFFF, 4'hF);
    wr(TIMER_STATUS, 32'd1, 4'hF);
    rd_check("status_w1c", TIMER_STATUS, 32'd0);
    check("irq_dropped", irq, 1'b0);

    // Back-to-back requests with VALID held high
    @(negedge clk);
    valid = 1'b1; wr_en = 1'b0; addr = TIMER_CMP_LO; wstrb = '0;
    check("b2b_ready_idle", ready, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("b2b_rvalid", rvalid, (i % 2) == 0);
      check("b2b_ready", ready, (i % 2) != 0);
      if ((i % 2) == 0) check("b2b_rdata", rdata, 32'hFFFF_FFFF);
    end
    valid = 1'b0;
    @(negedge clk);

    // Byte strobes, empty strobe, reserved word
    wr(TIMER_CMP_LO, 32'h1122_3344, 4'hF);
    wr(TIMER_CMP_LO, 32'hAABB_CCDD, 4'b0010);
    rd_check("wstrb_byte1", TIMER_CMP_LO, 32'h1122_CC44);
    wr(TIMER_CMP_LO, 32'h5555_5555, 4'b0000);
    rd_check("wstrb_none", TIMER_CMP_LO, 32'h1122_CC44);
    wr(5'h1C, 32'hFFFF_FFFF, 4'hF);
    rd_check("reserved_zero", 5'h1C, 32'd0);

    // Random register writes checked through a scoreboard queue
    reg_addr = '{TIMER_CTRL, TIMER_PRESC, TIMER_CMP_LO, TIMER_CMP_HI};
    reg_mask = '{32'h0000_0003, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    for (int r = 0; r < 4; r++) begin
      reg_val[r] = $urandom & reg_mask[r];
      wr(reg_addr[r], reg_val[r], 4'hF);
    end
    for (int it = 0; it < 16; it++) begin
      sel = $urandom_range(0, 3);
      a = reg_addr[sel];
      v = $urandom;
      s = 4'($urandom_range(0, 15));
      wr(a, v, s);
      for (int b = 0; b < 4; b++) begin
        if (s[b]) reg_val[sel][b*8 +: 8] = v[b*8 +: 8];
      end
      reg_val[sel] = reg_val[sel] & reg_mask[sel];
      exp_q.push_back(reg_val[sel]);
      access(1'b0, a, 32'd0, 4'd0, rd1);
      rd0 = exp_q.pop_front();
      check("rand_reg", rd1, rd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
